// File: rtl/score_fill_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_fill_controller_pkg
// Description : Shared Needleman-Wunsch definitions: controller state
//               encodings, default gap penalty, score width, clamp limits
//               and the saturating score helper.
// Revision    : 1.0 - initial release
// ============================================================================
package score_fill_controller_pkg;

    // 3-bit state encodings, shared with the traceback controller
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_init     = 3'd1;
    localparam logic [2:0] c_st_read     = 3'd2;
    localparam logic [2:0] c_st_wait_max = 3'd3;
    localparam logic [2:0] c_st_write    = 3'd4;
    localparam logic [2:0] c_st_next     = 3'd5;
    localparam logic [2:0] c_st_done     = 3'd6;

    localparam int c_gap_default = -2;
    localparam int c_score_w     = 9;
    localparam int c_score_min   = -256;
    localparam int c_score_max   = 255;

    typedef enum logic [2:0] {
        S_IDLE     = c_st_idle,
        S_INIT     = c_st_init,
        S_READ     = c_st_read,
        S_WAIT_MAX = c_st_wait_max,
        S_WRITE    = c_st_write,
        S_NEXT     = c_st_next,
        S_DONE     = c_st_done
    } fill_state_t;

    // Saturate a wide signed value into the 9-bit score range
    function automatic logic signed [c_score_w-1:0] clamp_score(input int value);
        if (value < c_score_min) begin
            return c_score_w'(c_score_min);
        end else if (value > c_score_max) begin
            return c_score_w'(c_score_max);
        end else begin
            return c_score_w'(value);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_fill_controller_iter.sv
`default_nettype none
// ============================================================================
// Module      : score_cell_iter
// Description : Row-major cell walker for the score matrix. Holds (i,j),
//               wraps j back to 1 at the end of a row while advancing i,
//               pulses change_index alongside the new row index and flags
//               the final cell (N,N).
// Revision    : 1.0 - initial release
// ============================================================================
module score_cell_iter #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_first,
    input  logic             step,
    output logic [BitAddr:0] i,
    output logic [BitAddr:0] j,
    output logic             last,
    output logic             change_index
);

    localparam int               c_w   = BitAddr + 1;
    localparam logic [BitAddr:0] c_n   = c_w'(N);
    localparam logic [BitAddr:0] c_one = c_w'(1);

    logic [BitAddr:0] r_i;
    logic [BitAddr:0] r_j;
    logic             r_change_index;

    // Coordinate registers: clear, jump to (1,1), or advance row-major
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_i            <= '0;
            r_j            <= '0;
            r_change_index <= 1'b0;
        end else begin
            r_change_index <= 1'b0;
            if (clear) begin
                r_i <= '0;
                r_j <= '0;
            end else if (load_first) begin
                r_i <= c_one;
                r_j <= c_one;
            end else if (step) begin
                if (r_j < c_n) begin
                    r_j <= r_j + c_one;
                end else if (r_i < c_n) begin
                    r_j            <= c_one;
                    r_i            <= r_i + c_one;
                    r_change_index <= 1'b1;
                end
            end
        end
    end

    assign i            = r_i;
    assign j            = r_j;
    assign change_index = r_change_index;
    assign last         = (r_i == c_n) && (r_j == c_n);

endmodule
`default_nettype wire

// File: rtl/score_fill_controller.sv
`default_nettype none
// ============================================================================
// Module      : score_fill_controller
// Description : Score-matrix fill sequencer. Writes the gap-penalty border
//               (row 0 / column 0), then walks cells (1,1)..(N,N) with a
//               read / wait-for-max / write-back handshake per cell.
//               All outputs are registered (Moore).
// Revision    : 1.0 - initial release
// ============================================================================
module score_fill_controller
    import score_fill_controller_pkg::*;
#(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1),
    parameter int GAP     = c_gap_default
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        hit,
    input  logic                        signal,
    input  logic                        max_valid,
    output logic                        en_init,
    output logic [BitAddr:0]            addr_init,
    output logic signed [c_score_w-1:0] data_init,
    output logic                        en_read,
    output logic                        change_index,
    output logic                        en_ins,
    output logic                        we,
    output logic [BitAddr:0]            i,
    output logic [BitAddr:0]            j,
    output logic                        busy,
    output logic                        done
);

    localparam int               c_w   = BitAddr + 1;
    localparam logic [BitAddr:0] c_n   = c_w'(N);
    localparam logic [BitAddr:0] c_one = c_w'(1);

    fill_state_t                 r_state;
    logic [BitAddr:0]            r_k;
    logic signed [c_score_w-1:0] r_data_init;
    logic                        r_en_init;
    logic                        r_en_read;
    logic                        r_en_ins;
    logic                        r_we;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_clear;
    logic                        w_load_first;
    logic                        w_step;
    logic                        w_last;
    logic [BitAddr:0]            w_k_next;
    logic signed [c_score_w-1:0] w_data_next;

    // Iterator control decoded from the current state and this cycle's inputs
    always_comb begin
        w_clear      = 1'b0;
        w_load_first = 1'b0;
        w_step       = 1'b0;
        if (r_state != S_IDLE) begin
            w_clear = abort;
        end else begin
            w_clear = start && !abort;
        end
        if (!abort) begin
            w_load_first = (r_state == S_INIT) && hit && (r_k == c_n);
            w_step       = (r_state == S_NEXT) && !w_last;
        end
    end

    // Border value for the next init index, saturated so a long row cannot wrap
    assign w_k_next    = r_k + c_one;
    assign w_data_next = clamp_score(int'(w_k_next) * GAP);

    score_cell_iter #(
        .N       (N),
        .BitAddr (BitAddr)
    ) u_iter (
        .clk          (clk),
        .rst          (rst),
        .clear        (w_clear),
        .load_first   (w_load_first),
        .step         (w_step),
        .i            (i),
        .j            (j),
        .last         (w_last),
        .change_index (change_index)
    );

    // Main sequencer; abort from any active state wins over normal progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_data_init <= '0;
            r_en_init   <= 1'b0;
            r_en_read   <= 1'b0;
            r_en_ins    <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if ((r_state != S_IDLE) && abort) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_data_init <= '0;
            r_en_init   <= 1'b0;
            r_en_read   <= 1'b0;
            r_en_ins    <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start && !abort) begin
                        r_state     <= S_INIT;
                        r_k         <= '0;
                        r_data_init <= '0;
                        r_en_init   <= 1'b1;
                        r_we        <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_INIT: begin
                    // each index is held through one row write and one column write
                    if (hit) begin
                        if (r_k == c_n) begin
                            r_state   <= S_READ;
                            r_en_init <= 1'b0;
                            r_we      <= 1'b0;
                            r_en_read <= 1'b1;
                        end else begin
                            r_k         <= w_k_next;
                            r_data_init <= w_data_next;
                        end
                    end
                end
                S_READ: begin
                    if (signal) begin
                        r_state   <= S_WAIT_MAX;
                        r_en_read <= 1'b0;
                    end
                end
                S_WAIT_MAX: begin
                    if (max_valid) begin
                        r_state  <= S_WRITE;
                        r_en_ins <= 1'b1;
                        r_we     <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state  <= S_NEXT;
                    r_en_ins <= 1'b0;
                    r_we     <= 1'b0;
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= S_READ;
                        r_en_read <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_en_init <= 1'b0;
                    r_en_read <= 1'b0;
                    r_en_ins  <= 1'b0;
                    r_we      <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign en_init   = r_en_init;
    assign addr_init = r_k;
    assign data_init = r_data_init;
    assign en_read   = r_en_read;
    assign en_ins    = r_en_ins;
    assign we        = r_we;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_score_fill_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_fill_controller
// Description : Self-checking bench for score_fill_controller (N=4 main
//               instance, N=128 instance for the border clamp). Behavioural
//               score-manager / max-unit models drive hit, signal, max_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_fill_controller;

    localparam int NA  = 4;
    localparam int BA  = $clog2(NA + 1);
    localparam int NB  = 128;
    localparam int BB  = $clog2(NB + 1);
    localparam int GAP = -2;

    logic clk;
    logic rst, start, abort, hit, signal, max_valid;
    logic en_init, en_read, change_index, en_ins, we, busy, done;
    logic [BA:0] addr_init, i, j;
    logic signed [8:0] data_init;

    logic start_b, abort_b, hit_b;
    logic en_init_b, en_read_b, change_index_b, en_ins_b, we_b, busy_b, done_b;
    logic [BB:0] addr_init_b, i_b, j_b;
    logic signed [8:0] data_init_b;

    score_fill_controller #(.N(NA), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hit(hit),
        .signal(signal), .max_valid(max_valid), .en_init(en_init),
        .addr_init(addr_init), .data_init(data_init), .en_read(en_read),
        .change_index(change_index), .en_ins(en_ins), .we(we), .i(i), .j(j),
        .busy(busy), .done(done)
    );

    score_fill_controller #(.N(NB), .GAP(GAP)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .hit(hit_b),
        .signal(1'b0), .max_valid(1'b0), .en_init(en_init_b),
        .addr_init(addr_init_b), .data_init(data_init_b), .en_read(en_read_b),
        .change_index(change_index_b), .en_ins(en_ins_b), .we(we_b), .i(i_b), .j(j_b),
        .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // observations
    int wr_q[$];
    int ci_q[$];
    int init_a[$];
    int init_d[$];
    int done_cnt = 0;
    int b_d127 = -999;
    int b_d128 = -999;

    // environment model state
    bit hit_ph = 0, hit_ph_b = 0;
    bit waiting = 0, prev_rd = 0;
    bit noise_en = 0, fixed_lat = 1;
    int rd_cnt = 0, mx_cnt = 0;
    int rd_lat = 3, mx_lat = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gap_value(input int k);
        int v;
        v = k * GAP;
        if (v < -256) v = -256;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic clear_obs();
        wr_q.delete();
        ci_q.delete();
        init_a.delete();
        init_d.delete();
        done_cnt = 0;
    endtask

    // One clock: observe outputs at the falling edge, then drive the models
    task automatic step();
        @(negedge clk);
        if (en_ins) wr_q.push_back(int'(i) * 100 + int'(j));
        if (change_index) ci_q.push_back(int'(i));
        if (en_init) begin
            init_a.push_back(int'(addr_init));
            init_d.push_back(int'(data_init));
        end
        if (done) done_cnt++;
        if (rst) begin
            check("en_exclusive", en_init & en_ins, 1'b0);
            check("we_scope", we, en_init | en_ins);
        end

        // score manager: row write then column write for every init index
        if (en_init) begin
            hit = hit_ph;
            hit_ph = ~hit_ph;
        end else begin
            hit = 1'b0;
            hit_ph = 1'b0;
        end

        // track the max-unit wait window (entered when en_read falls while busy)
        if (!busy) waiting = 1'b0;
        else if (prev_rd && !en_read) begin
            waiting = 1'b1;
            mx_cnt = 0;
        end
        if (en_ins) begin
            waiting = 1'b0;
            if (!fixed_lat) begin
                rd_lat = $urandom_range(1, 4);
                mx_lat = $urandom_range(0, 3);
            end
        end
        prev_rd = en_read;

        if (en_read) begin
            rd_cnt++;
            signal = (rd_cnt >= rd_lat);
        end else begin
            rd_cnt = 0;
            signal = noise_en && ($urandom_range(0, 3) == 0);
        end

        if (waiting) begin
            max_valid = (mx_cnt >= mx_lat);
            mx_cnt++;
        end else begin
            max_valid = noise_en && ($urandom_range(0, 3) == 0);
        end

        if (en_init_b) begin
            if (addr_init_b == 127) b_d127 = int'(data_init_b);
            if (addr_init_b == 128) b_d128 = int'(data_init_b);
            hit_b = hit_ph_b;
            hit_ph_b = ~hit_ph_b;
        end else begin
            hit_b = 1'b0;
            hit_ph_b = 1'b0;
        end
    endtask

    task automatic run_until_done(input int budget);
        for (int c = 0; c < budget && done_cnt == 0; c++) step();
        check("done_pulses", done_cnt, 1);
    endtask

    task automatic check_cells();
        int idx;
        check("cell_count", wr_q.size(), NA * NA);
        idx = 0;
        for (int r = 1; r <= NA; r++) begin
            for (int c = 1; c <= NA; c++) begin
                if (idx < wr_q.size()) check("cell_order", wr_q[idx], r * 100 + c);
                idx++;
            end
        end
        check("row_changes", ci_q.size(), NA - 1);
        for (int r = 2; r <= NA; r++) begin
            if (r - 2 < ci_q.size()) check("row_change_i", ci_q[r - 2], r);
        end
    endtask

    task automatic check_init();
        check("init_len", init_a.size(), 2 * (NA + 1));
        for (int k = 0; k <= NA; k++) begin
            for (int rep = 0; rep < 2; rep++) begin
                if (2 * k + rep < init_a.size()) begin
                    check("init_addr", init_a[2 * k + rep], k);
                    check("init_data", init_d[2 * k + rep], gap_value(k));
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit mid;
        bit found;
        rst = 1'b0; start = 1'b1; abort = 1'b0;
        hit = 1'b0; signal = 1'b0; max_valid = 1'b0;
        start_b = 1'b1; abort_b = 1'b0; hit_b = 1'b0;

        // reset held with start asserted
        step();
        step();
        check("rst_en_init", en_init, 0);
        check("rst_addr_init", addr_init, 0);
        check("rst_data_init", data_init, 0);
        check("rst_en_read", en_read, 0);
        check("rst_change_index", change_index, 0);
        check("rst_en_ins", en_ins, 0);
        check("rst_we", we, 0);
        check("rst_i", i, 0);
        check("rst_j", j, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_b_busy", busy_b, 0);
        rst = 1'b1; start = 1'b0; start_b = 1'b0;
        step();

        // abort together with start in IDLE stays idle
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_en_init", en_init, 0);

        // full run with fixed latencies: read done on 3rd cycle, max 1 cycle later
        clear_obs();
        fixed_lat = 1; rd_lat = 3; mx_lat = 0; noise_en = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && !en_read; c++) step();
        check_init();
        check("first_read_en", en_read, 1);
        check("first_read_i", i, 1);
        check("first_read_j", j, 1);
        run_until_done(400);
        step();
        check("after_done_busy", busy, 0);
        check("after_done_i", i, NA);
        check("after_done_j", j, NA);
        check_cells();

        // start asserted mid-run at (2,3) is ignored; random latencies and noise
        clear_obs();
        fixed_lat = 0; noise_en = 1;
        rd_lat = $urandom_range(1, 4); mx_lat = $urandom_range(0, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        mid = 0;
        for (int c = 0; c < 1000 && done_cnt == 0; c++) begin
            step();
            if (!mid && en_read && i == 2 && j == 3) begin
                start = 1'b1;
                step();
                start = 1'b0;
                mid = 1;
            end
        end
        check("mid_start_reached", mid, 1);
        check("mid_done_pulses", done_cnt, 1);
        check_init();
        check_cells();
        step();

        // abort during WAIT_MAX at (3,2)
        clear_obs();
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (waiting && i == 3 && j == 2) begin
                found = 1;
                break;
            end
        end
        check("abort_point_reached", found, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_i", i, 0);
        check("abort_j", j, 0);
        check("abort_en_ins", en_ins, 0);
        check("abort_we", we, 0);
        check("abort_en_read", en_read, 0);
        check("abort_addr_init", addr_init, 0);
        repeat (5) step();
        check("abort_writes", wr_q.size(), 9);
        if (wr_q.size() > 0) check("abort_last_write", wr_q[wr_q.size() - 1], 301);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 0);

        // restart after abort begins again from k=0
        clear_obs();
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_en_init", en_init, 1);
        check("restart_k0", addr_init, 0);
        check("restart_data0", data_init, 0);
        run_until_done(1000);
        check_init();
        check_cells();

        // N=128 instance: border value at k=128 saturates to -256
        noise_en = 0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int c = 0; c < 400 && !en_read_b; c++) step();
        check("b_read_reached", en_read_b, 1);
        check("b_data_k127", b_d127, -254);
        check("b_data_k128", b_d128, -256);
        check("b_i_first", i_b, 1);
        abort_b = 1'b1;
        step();
        abort_b = 1'b0;
        check("b_abort_busy", busy_b, 0);
        check("b_abort_i", i_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
